// File: rtl/ysyx_23060240_ifu.sv
// ysyx_23060240_ifu: instruction fetch unit of the single-issue NPC core.
//
// Holds the architectural PC, issues one word fetch at a time over a
// valid/ready request + one-cycle valid response interface, and hands the
// fetched instruction with its PC to the decoder over valid/ready.
// Redirects from execute override sequential PC+4 in every state.
//
// Optional feature macro: IFU_MISALIGN_CHK_EN
//   When defined, a PC with pc[1:0] != 0 in REQ issues no memory request;
//   the unit goes straight to OUT presenting a nop and raises `misalign`.
//   When undefined, the `misalign` port is absent and pc[1:0] reaches memory
//   unchecked.

module ysyx_23060240_ifu #(
  parameter int                XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              imem_req_valid,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_resp_valid,
  input  logic [31:0]       imem_resp_data,
  output logic              out_valid,
  output logic [XLEN-1:0]   out_pc,
  output logic [31:0]       out_inst,
  input  logic              out_ready,
  output logic [31:0]       fetch_cnt
`ifdef IFU_MISALIGN_CHK_EN
  ,
  output logic              misalign
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } state_e;

  localparam logic [31:0]     NOP_INST = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP  = 32'h0000_0004;

  // architectural state
  state_e          state_r;
  logic [XLEN-1:0] pc_r;
  logic            flush_r;
  logic [31:0]     inst_q_r;
  logic [31:0]     cnt_r;
  logic            mis_r;

  // next-state values
  state_e          state_nxt_s;
  logic [XLEN-1:0] pc_nxt_s;
  logic            flush_nxt_s;
  logic [31:0]     inst_q_nxt_s;
  logic [31:0]     cnt_nxt_s;
  logic            mis_nxt_s;

  // low PC bits set means the fetch must be suppressed (feature builds only)
  logic            pc_misaligned_s;

`ifdef IFU_MISALIGN_CHK_EN
  assign pc_misaligned_s = (pc_r[1:0] != 2'b00);
`else
  assign pc_misaligned_s = 1'b0;
`endif

  // state register: synchronous reset abandons any outstanding request
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      pc_r     <= RESET_PC;
      flush_r  <= 1'b0;
      inst_q_r <= 32'h0000_0000;
      cnt_r    <= 32'h0000_0000;
      mis_r    <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      pc_r     <= pc_nxt_s;
      flush_r  <= flush_nxt_s;
      inst_q_r <= inst_q_nxt_s;
      cnt_r    <= cnt_nxt_s;
      mis_r    <= mis_nxt_s;
    end
  end

  // next-state logic: a redirect always wins over the sequential path
  always_comb begin
    state_nxt_s  = state_r;
    pc_nxt_s     = pc_r;
    flush_nxt_s  = flush_r;
    inst_q_nxt_s = inst_q_r;
    cnt_nxt_s    = cnt_r;
    mis_nxt_s    = mis_r;

    case (state_r)
      IDLE: begin
        state_nxt_s = REQ;
        if (redirect_valid) begin
          pc_nxt_s = redirect_pc;
        end else begin
          pc_nxt_s = pc_r;
        end
      end

      REQ: begin
        if (redirect_valid) begin
          // retarget before anything is sent; re-evaluate next cycle
          pc_nxt_s    = redirect_pc;
          state_nxt_s = REQ;
        end else if (pc_misaligned_s) begin
          // no memory access; OUT presents a nop flagged as misaligned
          mis_nxt_s   = 1'b1;
          state_nxt_s = OUT;
        end else if (imem_req_ready) begin
          mis_nxt_s   = 1'b0;
          state_nxt_s = WAIT;
        end else begin
          state_nxt_s = REQ;
        end
      end

      WAIT: begin
        if (imem_resp_valid) begin
          if (flush_r) begin
            // response belongs to a fetch a redirect already killed
            flush_nxt_s = 1'b0;
            state_nxt_s = REQ;
            if (redirect_valid) begin
              pc_nxt_s = redirect_pc;
            end else begin
              pc_nxt_s = pc_r;
            end
          end else begin
            inst_q_nxt_s = imem_resp_data;
            if (redirect_valid) begin
              // captured, but the same-cycle redirect makes it stale
              pc_nxt_s    = redirect_pc;
              flush_nxt_s = 1'b0;
              state_nxt_s = REQ;
            end else begin
              state_nxt_s = OUT;
            end
          end
        end else begin
          if (redirect_valid) begin
            // last redirect wins; the pending response gets dropped
            pc_nxt_s    = redirect_pc;
            flush_nxt_s = 1'b1;
          end else begin
            flush_nxt_s = flush_r;
          end
          state_nxt_s = WAIT;
        end
      end

      OUT: begin
        if (redirect_valid) begin
          pc_nxt_s    = redirect_pc;
          state_nxt_s = REQ;
        end else if (out_ready) begin
          pc_nxt_s    = pc_r + PC_STEP;
          cnt_nxt_s   = cnt_r + 32'd1;
          state_nxt_s = REQ;
        end else begin
          state_nxt_s = OUT;
        end
      end

      default: begin
        state_nxt_s = IDLE;
        pc_nxt_s    = RESET_PC;
        flush_nxt_s = 1'b0;
      end
    endcase
  end

  // output decode: valids drop combinationally on a same-cycle redirect
  always_comb begin
    imem_req_valid = 1'b0;
    out_valid      = 1'b0;
    out_inst       = inst_q_r;
    imem_req_addr  = pc_r;
    out_pc         = pc_r;

    case (state_r)
      REQ: begin
        if (redirect_valid || pc_misaligned_s) begin
          imem_req_valid = 1'b0;
        end else begin
          imem_req_valid = 1'b1;
        end
      end
      OUT: begin
        out_valid = ~redirect_valid;
        if (mis_r) begin
          out_inst = NOP_INST;
        end else begin
          out_inst = inst_q_r;
        end
      end
      default: begin
        imem_req_valid = 1'b0;
        out_valid      = 1'b0;
      end
    endcase
  end

  assign fetch_cnt = cnt_r;

`ifdef IFU_MISALIGN_CHK_EN
  assign misalign = (state_r == OUT) && mis_r;
`endif

endmodule

// File: tb/tb_ysyx_23060240_ifu.sv
// Self-checking bench for ysyx_23060240_ifu: directed scenarios followed by
// a randomized run checked against a transaction-level reference model.
`timescale 1ns/1ps

module tb_ysyx_23060240_ifu;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_ready;
  logic [31:0] fetch_cnt;
`ifdef IFU_MISALIGN_CHK_EN
  logic        misalign;
`endif

  int n_cmp;
  int n_err;

  ysyx_23060240_ifu dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .out_valid       (out_valid),
    .out_pc          (out_pc),
    .out_inst        (out_inst),
    .out_ready       (out_ready),
    .fetch_cnt       (fetch_cnt)
`ifdef IFU_MISALIGN_CHK_EN
    ,
    .misalign        (misalign)
`endif
  );

  // free-running clock
  always #5 clk = ~clk;

  // memory contents used by the random run: a fixed function of the address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_0F1E;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst             = 1'b1;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    out_ready       = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp += 5;
    if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL reset_req_valid got %0b want 0", imem_req_valid); end
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    if (out_inst !== 32'h0) begin n_err++; $display("FAIL reset_out_inst got %h want 0", out_inst); end
    if (imem_req_addr !== 32'h8000_0000 || out_pc !== 32'h8000_0000) begin
      n_err++; $display("FAIL reset_pc got addr=%h out_pc=%h want 80000000", imem_req_addr, out_pc);
    end
    if (fetch_cnt !== 32'h0) begin n_err++; $display("FAIL reset_fetch_cnt got %0d want 0", fetch_cnt); end
  endtask

  task automatic test_basic();
    imem_req_ready = 1'b1;
    out_ready      = 1'b1;
    @(negedge clk); #1;
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000) begin
      n_err++; $display("FAIL basic_first_req got v=%0b a=%h want 1/80000000", imem_req_valid, imem_req_addr);
    end
    @(negedge clk);
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0000_0013;
    @(negedge clk);
    imem_resp_valid = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b1 || out_pc !== 32'h8000_0000 || out_inst !== 32'h0000_0013) begin
      n_err++; $display("FAIL basic_out got v=%0b pc=%h inst=%h want 1/80000000/00000013", out_valid, out_pc, out_inst);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0004 || fetch_cnt !== 32'd1) begin
      n_err++; $display("FAIL basic_next_req got v=%0b a=%h cnt=%0d want 1/80000004/1", imem_req_valid, imem_req_addr, fetch_cnt);
    end
  endtask

  task automatic test_stall();
    @(negedge clk);
    out_ready       = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0010_0093;
    @(negedge clk);
    imem_resp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_pc !== 32'h8000_0004 || out_inst !== 32'h0010_0093 ||
          imem_req_valid !== 1'b0 || fetch_cnt !== 32'd1) begin
        n_err++;
        $display("FAIL stall_hold cyc%0d got v=%0b pc=%h inst=%h req=%0b cnt=%0d want 1/80000004/00100093/0/1",
                 i, out_valid, out_pc, out_inst, imem_req_valid, fetch_cnt);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
  endtask

  task automatic test_redirect_wait();
    @(negedge clk); #1;
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0008) begin
      n_err++; $display("FAIL rw_req got v=%0b a=%h want 1/80000008", imem_req_valid, imem_req_addr);
    end
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_1000;
    imem_req_ready = 1'b0;
    @(negedge clk);
    redirect_valid = 1'b0;
    @(negedge clk);
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEAD_BEEF;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL rw_resp_cycle got out_valid=%0b want 0", out_valid); end
    @(negedge clk);
    imem_resp_valid = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_1000) begin
      n_err++; $display("FAIL rw_after got ov=%0b req=%0b a=%h want 0/1/80001000", out_valid, imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_redirect_out();
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h1234_5678;
    @(negedge clk);
    imem_resp_valid = 1'b0;
    redirect_valid  = 1'b1;
    redirect_pc     = 32'h8000_2000;
    out_ready       = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || fetch_cnt !== 32'd2) begin
      n_err++; $display("FAIL ro_cycle got ov=%0b cnt=%0d want 0/2", out_valid, fetch_cnt);
    end
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_2000 || fetch_cnt !== 32'd2) begin
      n_err++; $display("FAIL ro_next got req=%0b a=%h cnt=%0d want 1/80002000/2", imem_req_valid, imem_req_addr, fetch_cnt);
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    #1;
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin
      n_err++; $display("FAIL wrap_req got v=%0b a=%h want 1/fffffffc", imem_req_valid, imem_req_addr);
    end
    @(negedge clk);
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0000_0073;
    @(negedge clk);
    imem_resp_valid = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b1 || out_pc !== 32'hFFFF_FFFC) begin
      n_err++; $display("FAIL wrap_out got v=%0b pc=%h want 1/fffffffc", out_valid, out_pc);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_0000 || fetch_cnt !== 32'd3) begin
      n_err++; $display("FAIL wrap_next got v=%0b a=%h cnt=%0d want 1/00000000/3", imem_req_valid, imem_req_addr, fetch_cnt);
    end
  endtask

  task automatic test_reset_wait();
    imem_req_ready = 1'b1;
    @(negedge clk);
    rst            = 1'b1;
    imem_req_ready = 1'b0;
    @(negedge clk);
    rst             = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hBAD0_BAD0;
    #1;
    n_cmp++;
    if (imem_req_valid !== 1'b0 || out_valid !== 1'b0 || fetch_cnt !== 32'd0 || imem_req_addr !== 32'h8000_0000) begin
      n_err++; $display("FAIL rst_wait_idle got req=%0b ov=%0b cnt=%0d a=%h want 0/0/0/80000000",
                        imem_req_valid, out_valid, fetch_cnt, imem_req_addr);
    end
    @(negedge clk);
    imem_resp_valid = 1'b0;
    #1;
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL rst_wait_restart got req=%0b a=%h ov=%0b want 1/80000000/0", imem_req_valid, imem_req_addr, out_valid);
    end
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0000_0013;
    @(negedge clk);
    imem_resp_valid = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b1 || out_inst !== 32'h0000_0013 || out_pc !== 32'h8000_0000) begin
      n_err++; $display("FAIL rst_wait_fresh got v=%0b inst=%h pc=%h want 1/00000013/80000000", out_valid, out_inst, out_pc);
    end
  endtask

`ifdef IFU_MISALIGN_CHK_EN
  task automatic test_misalign();
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0002;
    @(negedge clk);
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    out_ready      = 1'b0;
    #1;
    n_cmp++;
    if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL mis_no_req got %0b want 0", imem_req_valid); end
    @(negedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b1 || out_inst !== 32'h0000_0013 || misalign !== 1'b1 || out_pc !== 32'h8000_0002 || imem_req_valid !== 1'b0) begin
      n_err++; $display("FAIL mis_out got v=%0b inst=%h mis=%0b pc=%h req=%0b want 1/00000013/1/80000002/0",
                        out_valid, out_inst, misalign, out_pc, imem_req_valid);
    end
  endtask
`endif

  // random run: model tracks the PC the program should be at, the one
  // outstanding fetch, and the number of delivered instructions
  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] exp_cnt;
    logic [31:0] pend_addr;
    bit          pending;
    int          pend_delay;
    int          idle_cycles;
    int          delivered;
    bit          req_fire;
    bit          out_fire;
    bit          resp_fire;

    do_reset();
    exp_pc      = 32'h8000_0000;
    exp_cnt     = 32'h0;
    pend_addr   = 32'h0;
    pending     = 1'b0;
    pend_delay  = 0;
    idle_cycles = 0;
    delivered   = 0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc > 0) @(negedge clk);
      redirect_valid = ($urandom_range(0, 99) < 8);
      redirect_pc    = {$urandom(), 2'b00} >> 0;
      redirect_pc[1:0] = 2'b00;
      if ($urandom_range(0, 19) == 0) redirect_pc = 32'hFFFF_FFFC;
      imem_req_ready = ($urandom_range(0, 3) != 0);
      out_ready      = ($urandom_range(0, 2) != 0);
      resp_fire      = 1'b0;
      if (pending) begin
        if (pend_delay == 0) begin
          imem_resp_valid = 1'b1;
          imem_resp_data  = mem_word(pend_addr);
          resp_fire       = 1'b1;
        end else begin
          imem_resp_valid = 1'b0;
          pend_delay--;
        end
      end else begin
        imem_resp_valid = ($urandom_range(0, 19) == 0);
        imem_resp_data  = $urandom();
      end
      #1;

      n_cmp++;
      if (fetch_cnt !== exp_cnt) begin
        n_err++; $display("FAIL rnd_cnt cyc%0d got %0d want %0d", cyc, fetch_cnt, exp_cnt);
      end
`ifdef IFU_MISALIGN_CHK_EN
      n_cmp++;
      if (misalign !== 1'b0) begin n_err++; $display("FAIL rnd_misalign cyc%0d got %0b want 0", cyc, misalign); end
`endif
      if (imem_req_valid === 1'b1) begin
        n_cmp++;
        if (pending || redirect_valid || imem_req_addr !== exp_pc) begin
          n_err++; $display("FAIL rnd_req cyc%0d got a=%h pend=%0b redir=%0b want a=%h pend=0 redir=0",
                            cyc, imem_req_addr, pending, redirect_valid, exp_pc);
        end
      end
      if (out_valid === 1'b1) begin
        n_cmp++;
        if (out_pc !== exp_pc || out_inst !== mem_word(exp_pc)) begin
          n_err++; $display("FAIL rnd_out cyc%0d got pc=%h inst=%h want pc=%h inst=%h",
                            cyc, out_pc, out_inst, exp_pc, mem_word(exp_pc));
        end
      end

      req_fire = (imem_req_valid === 1'b1) && imem_req_ready;
      out_fire = (out_valid === 1'b1) && out_ready;
      if (resp_fire) pending = 1'b0;
      if (req_fire) begin
        pending    = 1'b1;
        pend_addr  = imem_req_addr;
        pend_delay = $urandom_range(0, 2);
      end
      if (out_fire) begin
        exp_cnt = exp_cnt + 32'd1;
        exp_pc  = exp_pc + 32'd4;
        delivered++;
        idle_cycles = 0;
      end else begin
        idle_cycles++;
      end
      if (redirect_valid) exp_pc = redirect_pc;

      if (idle_cycles > 300) begin
        n_cmp++;
        n_err++;
        $display("FAIL rnd_timeout cyc%0d no delivery for %0d cycles", cyc, idle_cycles);
        break;
      end
    end
    n_cmp++;
    if (delivered < 100) begin
      n_err++; $display("FAIL rnd_delivered got %0d want >= 100", delivered);
    end
  endtask

  initial begin
    clk             = 1'b0;
    rst             = 1'b1;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    out_ready       = 1'b0;
    n_cmp           = 0;
    n_err           = 0;

    test_reset();
    test_basic();
    test_stall();
    test_redirect_wait();
    test_redirect_out();
    test_wrap();
    test_reset_wait();
`ifdef IFU_MISALIGN_CHK_EN
    test_misalign();
`endif
    test_random();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
